// File: rtl/param_est_nn_sdiv_26s_16ns_seq_if.sv
// Operand/result channel of the signed-by-unsigned sequential divider.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high,
// and the sender keeps valid and its payload unchanged until that edge.
interface param_est_nn_sdiv_26s_16ns_seq_if #(
  parameter int DIVIDEND_WIDTH = 26,
  parameter int DIVISOR_WIDTH  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH:0]    remainder;
  logic                      div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/param_est_nn_sdiv_26s_16ns_seq.sv
// Radix-2 restoring divider: signed dividend / unsigned divisor, one quotient bit per cycle,
// magnitude division followed by a single sign-fix cycle; one operation in flight.
module param_est_nn_sdiv_26s_16ns_seq #(
  parameter int DIVIDEND_WIDTH = 26,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic ap_clk,
  input  logic ap_rst,
  param_est_nn_sdiv_26s_16ns_seq_if.slave bus,
  output logic [1:0] state_dbg
);
  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [DW-1:0] ONE_D    = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [VW:0]   ONE_R    = {{VW{1'b0}}, 1'b1};
  localparam logic [DW-1:0] Q_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] mag;   // dividend magnitude shifting out, quotient bits shifting in
  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic          neg;
  logic          zdiv;

  logic [DW-1:0] abs_in;
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;
  logic [VW:0]   rem_ext;

  // -2^(DW-1) maps to 2^(DW-1), which is exact as an unsigned DW-bit magnitude.
  assign abs_in  = bus.dividend[DW-1] ? (~bus.dividend + ONE_D) : bus.dividend;
  assign trial   = {rem, mag[DW-1]};
  assign diff    = trial - {1'b0, dvs};
  assign fits    = (trial >= {1'b0, dvs});
  assign rem_ext = {1'b0, rem};

  assign state_dbg = state;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state           <= IDLE;
      cnt             <= '0;
      mag             <= '0;
      rem             <= '0;
      dvs             <= '0;
      neg             <= 1'b0;
      zdiv            <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag          <= abs_in;
            dvs          <= bus.divisor;
            neg          <= bus.dividend[DW-1];
            zdiv         <= (bus.divisor == '0);
            rem          <= '0;
            cnt          <= CNT_LAST;
            bus.in_ready <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          if (fits) begin
            rem <= diff[VW-1:0];
            mag <= {mag[DW-2:0], 1'b1};
          end else begin
            rem <= trial[VW-1:0];
            mag <= {mag[DW-2:0], 1'b0};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CNT_ONE;
        end
        FIX: begin
          // Magnitude zero negates to zero, so a zero dividend never yields a signed artefact.
          if (zdiv) begin
            bus.quotient  <= neg ? Q_MIN : Q_MAX;
            bus.remainder <= '0;
          end else begin
            bus.quotient  <= neg ? (~mag + ONE_D) : mag;
            bus.remainder <= neg ? (~rem_ext + ONE_R) : rem_ext;
          end
          bus.div_by_zero <= zdiv;
          bus.out_valid   <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_est_nn_sdiv_26s_16ns_seq.sv
// Bench for the sequential signed divider: directed corner cases plus random operands,
// checked against an integer-arithmetic reference model.
module tb_param_est_nn_sdiv_26s_16ns_seq;
  logic       ap_clk;
  logic       ap_rst;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;
  logic [43:0] exp_q[$];

  param_est_nn_sdiv_26s_16ns_seq_if bus ();

  param_est_nn_sdiv_26s_16ns_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed result: {div_by_zero, quotient[25:0], remainder[16:0]}
  function automatic logic [43:0] model(input logic [25:0] a, input logic [15:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 16'd0)
      return {1'b1, (a[25] ? 26'h2000000 : 26'h1FFFFFF), 17'd0};
    sa = longint'($signed(a));
    sb = longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {1'b0, q[25:0], r[16:0]};
  endfunction

  task automatic run_op(input logic [25:0] a, input logic [15:0] b, input int hold);
    logic [43:0] exp;
    int waitc;
    int lat;
    waitc = 0;
    while (bus.in_ready !== 1'b1 && waitc < 50) begin
      @(posedge ap_clk); #1;
      waitc++;
    end
    check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(model(a, b));
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 26'($urandom);
    bus.divisor  = 16'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    check_eq("latency", 64'(lat), 64'd27);
    exp = exp_q.pop_front();
    check_eq("result", 64'({bus.div_by_zero, bus.quotient, bus.remainder}), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.dividend = 26'($urandom);
      bus.divisor  = 16'($urandom);
      @(posedge ap_clk); #1;
      check_eq("hold_stable",
               64'({bus.out_valid, bus.in_ready, bus.div_by_zero, bus.quotient, bus.remainder}),
               64'({1'b1, 1'b0, exp}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.out_ready = 1'b0;
    check_eq("release", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    check_eq("retain_q", 64'(bus.quotient), 64'(exp[42:17]));
  endtask

  initial begin
    logic [15:0] rb;
    int sel;
    ap_rst        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check_eq("reset_outs",
             64'({bus.out_valid, bus.in_ready, bus.div_by_zero, bus.quotient, bus.remainder}),
             64'({1'b0, 1'b1, 1'b0, 26'd0, 17'd0}));

    run_op(26'd1000, 16'd7, 0);
    run_op(26'(-1000), 16'd7, 1);
    run_op(26'd7, 16'd65535, 0);
    run_op(26'h2000000, 16'd1, 0);
    run_op(26'd33554431, 16'd65535, 2);
    run_op(26'd5, 16'd0, 0);
    run_op(26'(-5), 16'd0, 0);
    run_op(26'd9, 16'd3, 0);
    run_op(26'd0, 16'd5, 0);
    run_op(26'd0, 16'd0, 0);
    run_op(26'd123456, 16'd321, 10);

    // Abort a division mid-way with reset, then confirm a clean restart.
    bus.in_valid = 1'b1;
    bus.dividend = 26'(-777777);
    bus.divisor  = 16'd13;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check_eq("rst_mid_outs", 64'({bus.out_valid, bus.quotient, bus.remainder}), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check_eq("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    run_op(26'd100, 16'd9, 0);

    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 16'd0;
        1:       rb = 16'd1;
        2:       rb = 16'hFFFF;
        3, 4, 5: rb = 16'($urandom_range(1, 255));
        default: rb = 16'($urandom);
      endcase
      run_op(26'($urandom), rb, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
